alu_result_stage: RTL

- Registered stage directly downstream of the 4-bit add/sub datapath.
- Captures each sum/carry result and derives the zero, negative and signed-overflow flags.
- Buffers results in a small FIFO with a valid/ready handshake toward the consumer (register file / display).
- Keeps a wrapping count of accepted operations and a sticky overflow flag.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_result_stage_if.sv | 34 +++
 rtl/alu_flag_gen.sv | 27 ++
 rtl/alu_result_stage.sv | 100 ++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, flag bit positions and the packed
// result record produced by the flag generator and held by result buffers.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 4;

    // Bit positions of the flags within alu_result_t (LSB side of the record).
    localparam int unsigned FLAG_OVF   = 0;
    localparam int unsigned FLAG_NEG   = 1;
    localparam int unsigned FLAG_ZERO  = 2;
    localparam int unsigned FLAG_CARRY = 3;

    typedef struct packed {
        logic [ALU_WIDTH-1:0] result;
        logic                 carry;
        logic                 zero;
        logic                 neg;
        logic                 ovf;
    } alu_result_t;

endpackage

// File: rtl/alu_result_stage_if.sv
// Handshake bus for the ALU result stage.
//   Producer side: in_valid/in_ready with in_sum, in_carry, in_a_msb, in_b_msb.
//   Consumer side: out_valid/out_ready with out_result and the head flags.
// master = producer/consumer environment, slave = the result stage.
interface alu_result_stage_if #(
    parameter int unsigned WIDTH = alu_pkg::ALU_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_sum;
    logic             in_carry;
    logic             in_a_msb;
    logic             in_b_msb;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_carry;
    logic             out_zero;
    logic             out_neg;
    logic             out_ovf;

    modport master (
        output in_valid, in_sum, in_carry, in_a_msb, in_b_msb, out_ready,
        input  in_ready, out_valid, out_result, out_carry, out_zero,
               out_neg, out_ovf
    );

    modport slave (
        input  in_valid, in_sum, in_carry, in_a_msb, in_b_msb, out_ready,
        output in_ready, out_valid, out_result, out_carry, out_zero,
               out_neg, out_ovf
    );
endinterface

// File: rtl/alu_flag_gen.sv
// Combinational flag generator for an add/sub result.
//   sum      : adder sum bits
//   carry    : adder carry-out (passed through)
//   a_msb    : MSB of operand A
//   b_msb    : MSB of the effective B operand
//   result_c : packed result record {result, carry, zero, neg, ovf}
module alu_flag_gen
    import alu_pkg::*;
(
    input  logic [ALU_WIDTH-1:0] sum,
    input  logic                 carry,
    input  logic                 a_msb,
    input  logic                 b_msb,
    output alu_result_t          result_c
);

    // Signed overflow: operands agree in sign but the sum does not.
    always_comb begin
        result_c        = '0;
        result_c.result = sum;
        result_c.carry  = carry;
        result_c.zero   = (sum == '0);
        result_c.neg    = sum[ALU_WIDTH-1];
        result_c.ovf    = (a_msb == b_msb) & (sum[ALU_WIDTH-1] != a_msb);
    end

endmodule

// File: rtl/alu_result_stage.sv
// Registered result stage behind the add/sub datapath: flags each result,
// buffers it in a small FIFO and presents it with valid/ready.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   clear      : flush buffer and sticky flag (counter untouched)
//   bus        : producer/consumer handshake (slave modport)
//   op_count   : wrapping count of accepted pushes
//   sticky_ovf : set by any pushed entry with signed overflow
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    alu_result_stage_if.slave bus,
    output logic [CNT_W-1:0] op_count,
    output logic             sticky_ovf
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    alu_result_t      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;

    alu_result_t      new_entry_c;
    alu_result_t      head_c;
    logic             push_c;
    logic             pop_c;

    // Flags are computed once at push time and stored with the entry.
    alu_flag_gen u_flag_gen (
        .sum      (ALU_WIDTH'(bus.in_sum)),
        .carry    (bus.in_carry),
        .a_msb    (bus.in_a_msb),
        .b_msb    (bus.in_b_msb),
        .result_c (new_entry_c)
    );

    // Ready depends only on stored occupancy, so a same-cycle pop never frees a slot.
    assign bus.in_ready = (occ < OCC_W'(DEPTH)) & ~reset;

    // Clear discards any handshake seen in the same cycle.
    assign push_c = bus.in_valid  & bus.in_ready  & ~clear;
    assign pop_c  = bus.out_valid & bus.out_ready & ~clear;

    // Head outputs are forced to zero when empty so stale storage never leaks.
    assign head_c         = mem[rd_ptr];
    assign bus.out_valid  = (occ != '0);
    assign bus.out_result = bus.out_valid ? WIDTH'(head_c.result) : '0;
    assign bus.out_carry  = bus.out_valid & head_c.carry;
    assign bus.out_zero   = bus.out_valid & head_c.zero;
    assign bus.out_neg    = bus.out_valid & head_c.neg;
    assign bus.out_ovf    = bus.out_valid & head_c.ovf;

    // Entry storage; contents are only observable through the gated head.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= new_entry_c;
        end
    end

    // Pointers, occupancy, counter and sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            op_count   <= '0;
            sticky_ovf <= 1'b0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            sticky_ovf <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr   <= wr_ptr + PTR_W'(1);
                op_count <= op_count + CNT_W'(1);
                if (new_entry_c.ovf) begin
                    sticky_ovf <= 1'b1;
                end
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_c, pop_c})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

endmodule
